// File: rtl/mem_bus_monitor.sv
// mem_bus_monitor
//
// Passive watcher for the core-to-memory bus. It samples every bus cycle,
// logs accesses that fall in the MMIO window into a first-word-fall-through
// FIFO with a ready/valid drain, and raises sticky end-of-run flags when the
// core touches the halt address or the cycle budget runs out.
//
// Optional feature macro: MON_DISPLAY_EN
//   When defined, the monitor prints each accepted MMIO access and the
//   halt/timeout event, then calls $finish one cycle after the run ends.
//   When undefined, no system tasks are compiled.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   mon_address   in   bus address, sampled every cycle
//   mon_data_wr   in   core->memory write data
//   mon_data_rd   in   memory->core read data
//   mon_we        in   bus write enable
//   halt          out  sticky, halt address reached
//   timeout       out  sticky, cycle budget expired
//   done          out  halt | timeout
//   log_valid     out  log head entry valid
//   log_ready     in   consumer pops head on log_valid & log_ready
//   log_is_write  out  head entry direction (1 = write)
//   log_addr      out  head entry address
//   log_data      out  head entry data
//   log_overflow  out  sticky, at least one entry dropped
//   cycle_count   out  cycles spent in RUN
//   access_count  out  MMIO accesses seen (saturating), dropped ones included
module mem_bus_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MMIO_BIT = 11,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = ADDR_WIDTH'('hFFC),
  parameter int TIMEOUT_CYCLES = 25,
  parameter int LOG_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mon_address,
  input  logic [DATA_WIDTH-1:0] mon_data_wr,
  input  logic [DATA_WIDTH-1:0] mon_data_rd,
  input  logic                  mon_we,
  output logic                  halt,
  output logic                  timeout,
  output logic                  done,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic                  log_is_write,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [DATA_WIDTH-1:0] log_data,
  output logic                  log_overflow,
  output logic [31:0]           cycle_count,
  output logic [15:0]           access_count
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {RUN, HALTED, TIMED_OUT} state_t;

  state_t state;

  logic [ENTRY_W-1:0] log_mem [LOG_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  logic is_halt;
  logic is_mmio;
  logic at_budget;
  logic fifo_full;
  logic pop;
  logic push;
  logic push_ok;

  assign is_halt   = (mon_address == HALT_ADDR);
  assign is_mmio   = mon_address[MMIO_BIT] && !is_halt;
  assign at_budget = (cycle_count == 32'(TIMEOUT_CYCLES - 1));

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fifo_full = ((wr_ptr - rd_ptr) == (PTR_W + 1)'(LOG_DEPTH));
  assign log_valid = (wr_ptr != rd_ptr);
  assign pop       = log_valid && log_ready;
  assign push      = (state == RUN) && is_mmio;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push && (!fifo_full || pop);

  // Head of the FIFO is shown directly; the storage is cleared on reset so the
  // log outputs read zero until the first entry arrives.
  assign {log_is_write, log_addr, log_data} = log_mem[rd_ptr[PTR_W-1:0]];

  // Run-control FSM with the flags and counters. The timeout cycle is still a
  // RUN cycle that consumed budget, so cycle_count ends at TIMEOUT_CYCLES; the
  // halt access ends the run before it is counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      halt         <= 1'b0;
      timeout      <= 1'b0;
      done         <= 1'b0;
      cycle_count  <= '0;
      access_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (is_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
            done  <= 1'b1;
          end else begin
            if (at_budget) begin
              state   <= TIMED_OUT;
              timeout <= 1'b1;
              done    <= 1'b1;
            end
            cycle_count <= cycle_count + 32'd1;
            if (is_mmio && (access_count != 16'hFFFF)) begin
              access_count <= access_count + 16'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Log FIFO storage and pointers. Draining continues after the run ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_overflow <= 1'b0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
        log_mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        log_mem[wr_ptr[PTR_W-1:0]] <= {mon_we, mon_address,
                                       mon_we ? mon_data_wr : mon_data_rd};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !push_ok) begin
        log_overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef MON_DISPLAY_EN
  logic finish_pending;

  // Trace printing; the run stops one cycle after entering a terminal state
  // so the final flag values are visible for a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      finish_pending <= 1'b0;
    end else begin
      if (finish_pending) begin
        $finish;
      end
      if (state == RUN) begin
        if (is_halt) begin
          $display("Address reached %0h. Stopping simulation.", HALT_ADDR);
          finish_pending <= 1'b1;
        end else begin
          if (push_ok) begin
            if (mon_we) begin
              $display("=== M[0x%0h] <- 0x%0h", mon_address, mon_data_wr);
            end else begin
              $display("=== M[0x%0h] -> 0x%0h", mon_address, mon_data_rd);
            end
          end
          if (at_budget) begin
            $display("Timeout after %0d cycles.", TIMEOUT_CYCLES);
            finish_pending <= 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_monitor.sv
// tb_mem_bus_monitor
//
// Drives mem_bus_monitor with directed scenarios followed by randomized bus
// traffic. A behavioural model tracks the run state, counters and FIFO
// occupancy; expected log entries go into a scoreboard queue that a separate
// monitor process consumes whenever the DUT hands over an entry.
module tb_mem_bus_monitor;

  localparam int TIMEOUT_CYCLES = 25;
  localparam int LOG_DEPTH = 8;
  localparam logic [31:0] HALT_ADDR = 32'hFFC;

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  logic        clk;
  logic        reset;
  logic [31:0] mon_address;
  logic [31:0] mon_data_wr;
  logic [31:0] mon_data_rd;
  logic        mon_we;
  logic        halt;
  logic        timeout;
  logic        done;
  logic        log_valid;
  logic        log_ready;
  logic        log_is_write;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic [31:0] cycle_count;
  logic [15:0] access_count;

  int compared = 0;
  int mismatched = 0;

  entry_t exp_q[$];

  // Behavioural model of the monitor's observable state.
  bit model_valid = 0;
  bit running;
  bit halted;
  bit timed_out;
  bit overflow;
  int run_cycles;
  int accesses;
  int occupancy;

  mem_bus_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .mon_address  (mon_address),
    .mon_data_wr  (mon_data_wr),
    .mon_data_rd  (mon_data_rd),
    .mon_we       (mon_we),
    .halt         (halt),
    .timeout      (timeout),
    .done         (done),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_is_write (log_is_write),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_overflow (log_overflow),
    .cycle_count  (cycle_count),
    .access_count (access_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare the flags and counters against the model state for this cycle.
  task automatic check_output();
    if (model_valid) begin
      check("halt", halt, halted);
      check("timeout", timeout, timed_out);
      check("done", done, halted || timed_out);
      check("log_overflow", log_overflow, overflow);
      check("cycle_count", cycle_count, run_cycles);
      check("access_count", access_count, accesses);
      check("log_valid", log_valid, occupancy > 0);
    end
  endtask

  // Advance the model by one bus cycle using the rules for the monitor.
  task automatic update_model(input logic rst, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic ready);
    bit popped;
    entry_t e;
    if (rst) begin
      model_valid = 1;
      running = 1;
      halted = 0;
      timed_out = 0;
      overflow = 0;
      run_cycles = 0;
      accesses = 0;
      occupancy = 0;
      exp_q.delete();
      return;
    end
    popped = (occupancy > 0) && ready;
    if (running) begin
      if (addr == HALT_ADDR) begin
        halted = 1;
        running = 0;
      end else begin
        if (addr[11]) begin
          if (accesses < 65535) accesses++;
          if (occupancy < LOG_DEPTH || popped) begin
            e.is_write = we;
            e.addr = addr;
            e.data = we ? wdata : rdata;
            exp_q.push_back(e);
            occupancy++;
          end else begin
            overflow = 1;
          end
        end
        run_cycles++;
        if (run_cycles == TIMEOUT_CYCLES) begin
          timed_out = 1;
          running = 0;
        end
      end
    end
    if (popped) occupancy--;
  endtask

  // One bus cycle: drive inputs just after the edge, check before the next
  // falling edge, then advance the model.
  task automatic apply_stimulus(input logic rst, input logic [31:0] addr,
                                input logic we, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic ready);
    reset = rst;
    mon_address = addr;
    mon_we = we;
    mon_data_wr = wdata;
    mon_data_rd = rdata;
    log_ready = ready;
    #3;
    check_output();
    update_model(rst, addr, we, wdata, rdata, ready);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    apply_stimulus(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, ready);
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, 32'h0, 1'b0, $urandom, $urandom, ready);
    end
  endtask

  // Scoreboard consumer: every handshake on the log port must match the
  // oldest expected entry. Pops during reset are discarded by the DUT.
  always @(negedge clk) begin
    entry_t e;
    if (reset === 1'b0 && log_valid === 1'b1 && log_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_entry: got addr 0x%0h, expected no entry",
                 log_addr);
      end else begin
        e = exp_q.pop_front();
        check("log_is_write", log_is_write, e.is_write);
        check("log_addr", log_addr, e.addr);
        check("log_data", log_data, e.data);
      end
    end
  end

  initial begin
    logic [31:0] addr;
    int r;
    int ready_pct;

    reset = 1'b1;
    mon_address = '0;
    mon_we = 1'b0;
    mon_data_wr = '0;
    mon_data_rd = '0;
    log_ready = 1'b0;
    @(posedge clk);
    #1;

    // Idle bus until the budget expires; reset values checked first.
    do_reset(1'b1);
    check("reset_log_is_write", log_is_write, 1'b0);
    check("reset_log_addr", log_addr, 32'h0);
    check("reset_log_data", log_data, 32'h0);
    idle(30, 1'b1);

    // Write then read in the MMIO window, drained immediately.
    do_reset(1'b1);
    apply_stimulus(1'b0, 32'h800, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1);
    apply_stimulus(1'b0, 32'h804, 1'b0, 32'hAAAA5555, 32'h12345678, 1'b1);
    idle(4, 1'b1);
    check("queue_drained", exp_q.size(), 0);

    // Halt access in the fifth run cycle, then an ignored MMIO access.
    do_reset(1'b1);
    idle(4, 1'b1);
    apply_stimulus(1'b0, HALT_ADDR, 1'b1, 32'h1, 32'h2, 1'b1);
    apply_stimulus(1'b0, 32'h900, 1'b1, 32'h3, 32'h4, 1'b1);
    idle(3, 1'b1);

    // Ten writes into a stalled FIFO, then drain.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 32'h800 + 32'(4 * i), 1'b1, 32'hC000_0000 + 32'(i),
                     32'h0, 1'b0);
    end
    idle(2, 1'b0);
    idle(10, 1'b1);

    // Full FIFO takes a ninth entry when the head leaves the same cycle.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 32'hA00 + 32'(i), 1'b0, 32'h0, 32'h5000_0000 + 32'(i),
                     1'b0);
    end
    apply_stimulus(1'b0, 32'hA40, 1'b1, 32'h9999_0009, 32'h0, 1'b1);
    idle(10, 1'b1);

    // Reset with entries queued after a halt, then counting resumes.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 32'hB00 + 32'(i), 1'b1, 32'h7000_0000 + 32'(i),
                     32'h0, 1'b0);
    end
    apply_stimulus(1'b0, HALT_ADDR, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1, 1'b0);
    do_reset(1'b1);
    idle(2, 1'b1);
    apply_stimulus(1'b0, 32'h820, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic with varying consumer throughput.
    for (int round = 0; round < 8; round++) begin
      ready_pct = 10 + round * 12;
      do_reset($urandom_range(0, 1));
      for (int c = 0; c < 40; c++) begin
        r = $urandom_range(0, 99);
        if (r < 3) addr = HALT_ADDR;
        else if (r < 55) addr = 32'h800 | 32'($urandom_range(0, 32'h7FF));
        else addr = 32'($urandom_range(0, 32'h7FF));
        if (round == 7 && c == 39) addr = 32'h0;
        apply_stimulus(1'b0, addr, 1'($urandom_range(0, 1)), $urandom, $urandom,
                       $urandom_range(0, 99) < ready_pct);
      end
    end

    // Final drain: everything the model expected must have been delivered.
    idle(LOG_DEPTH + 2, 1'b1);
    check("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
